apb4_ps2_host_tx: RTL

//  APB4-programmable PS/2 host-to-device transmitter, the send side of the PS/2 keyboard receiver.

---
 rtl/apb4_ps2_host_tx.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/apb4_ps2_host_tx.sv
// rtl/apb4_ps2_host_tx.sv - APB4 PS/2 host-to-device command transmitter
// Optional TX FIFO selected by defining PS2_TX_FIFO_EN; default is a single holding register.
module apb4_ps2_host_tx #(
  parameter int INHIBIT_CYC = 10000,
  parameter int TIMEOUT_CYC = 2000000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic [11:0] paddr,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  input  logic        ps2_clk_i,
  input  logic        ps2_dat_i,
  output logic        ps2_clk_oe,
  output logic        ps2_dat_oe,
  output logic        irq_o
);

  localparam int CNT_MAX = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_INHIBIT, S_XFER, S_WAIT_HI} state_t;

  state_t      r_state, w_state_nxt;
  logic        r_clk_oe, r_dat_oe, w_clk_oe_nxt, w_dat_oe_nxt;
  logic [CW-1:0] r_cnt;
  logic [3:0]  r_bit;
  logic [7:0]  r_shift;
  logic        r_par;
  logic        r_busy, r_done, r_err, r_nack, r_irqen;
  logic [2:0]  r_clk_sync;
  logic [1:0]  r_dat_sync;

  logic        w_acc, w_wr_tx, w_wr_st, w_wr_ctrl, w_rd;
  logic        w_fall, w_rise, w_tmo;
  logic        w_load, w_set_done, w_set_err, w_set_nack, w_cnt_clr, w_bit_inc;
  logic        w_pend, w_refuse;
  logic [7:0]  w_head;
  logic [1:0]  w_st_ext;
  logic [2:0]  w_w1c;
  logic        w_unused;

  assign w_acc     = psel & penable;
  assign w_wr_tx   = w_acc & pwrite & (paddr[3:2] == 2'd0);
  assign w_wr_st   = w_acc & pwrite & (paddr[3:2] == 2'd1);
  assign w_wr_ctrl = w_acc & pwrite & (paddr[3:2] == 2'd2);
  assign w_rd      = w_acc & ~pwrite;
  assign w_w1c     = w_wr_st ? pwdata[3:1] : 3'b000;
  assign w_unused  = &{1'b0, paddr[11:4], paddr[1:0], pwdata[31:8]};

  assign w_fall = r_clk_sync[2] & ~r_clk_sync[1];
  assign w_rise = ~r_clk_sync[2] & r_clk_sync[1];
  assign w_tmo  = (r_cnt == CW'(TIMEOUT_CYC - 1));

`ifdef PS2_TX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [7:0]  r_fifo [FIFO_DEPTH];
  logic [AW:0] r_wptr, r_rptr;
  logic        w_full, w_empty;

  assign w_full   = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_empty  = (r_wptr == r_rptr);
  assign w_pend   = ~w_empty;
  assign w_head   = r_fifo[r_rptr[AW-1:0]];
  assign w_refuse = w_full;
  assign w_st_ext = {w_empty, w_full};

  always_ff @(posedge hclk) begin
    if (w_wr_tx && !w_full) r_fifo[r_wptr[AW-1:0]] <= pwdata[7:0];
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr_tx && !w_full) r_wptr <= r_wptr + 1'b1;
      if (w_load)             r_rptr <= r_rptr + 1'b1;
    end
  end
`else
  logic [7:0] r_hold;
  logic       r_pend;

  assign w_pend   = r_pend;
  assign w_head   = r_hold;
  assign w_refuse = r_busy | r_pend;
  assign w_st_ext = 2'b00;

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      r_hold <= '0;
      r_pend <= 1'b0;
    end else if (w_wr_tx && !w_refuse) begin
      r_hold <= pwdata[7:0];
      r_pend <= 1'b1;
    end else if (w_load) begin
      r_pend <= 1'b0;
    end
  end
`endif

  // Data line goes low one cycle before the clock is released so the device sees a clean start.
  always_comb begin
    w_state_nxt  = r_state;
    w_clk_oe_nxt = 1'b0;
    w_dat_oe_nxt = 1'b0;
    w_load       = 1'b0;
    w_set_done   = 1'b0;
    w_set_err    = 1'b0;
    w_set_nack   = 1'b0;
    w_cnt_clr    = 1'b0;
    w_bit_inc    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_pend) begin
          w_load       = 1'b1;
          w_cnt_clr    = 1'b1;
          w_clk_oe_nxt = 1'b1;
          w_state_nxt  = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        w_clk_oe_nxt = 1'b1;
        w_dat_oe_nxt = (r_cnt == CW'(INHIBIT_CYC - 2));
        if (r_cnt == CW'(INHIBIT_CYC - 1)) begin
          w_clk_oe_nxt = 1'b0;
          w_dat_oe_nxt = 1'b1;
          w_cnt_clr    = 1'b1;
          w_state_nxt  = S_XFER;
        end
      end
      S_XFER: begin
        w_dat_oe_nxt = r_dat_oe;
        if (w_tmo) begin
          w_set_err    = 1'b1;
          w_dat_oe_nxt = 1'b0;
          w_state_nxt  = S_IDLE;
        end else if (w_fall) begin
          w_bit_inc = 1'b1;
          if (r_bit < 4'd8) begin
            w_dat_oe_nxt = ~r_shift[r_bit[2:0]];
          end else if (r_bit == 4'd8) begin
            w_dat_oe_nxt = ~r_par;
          end else if (r_bit == 4'd9) begin
            w_dat_oe_nxt = 1'b0;
          end else begin
            w_dat_oe_nxt = 1'b0;
            w_set_nack   = r_dat_sync[1];
            w_state_nxt  = S_WAIT_HI;
          end
        end
      end
      S_WAIT_HI: begin
        if (w_tmo) begin
          w_set_err   = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_rise) begin
          w_set_done  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      r_state    <= S_IDLE;
      r_clk_oe   <= 1'b0;
      r_dat_oe   <= 1'b0;
      r_cnt      <= '0;
      r_bit      <= '0;
      r_shift    <= '0;
      r_par      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_nack     <= 1'b0;
      r_irqen    <= 1'b0;
      r_clk_sync <= 3'b111;
      r_dat_sync <= 2'b11;
    end else begin
      r_clk_sync <= {r_clk_sync[1:0], ps2_clk_i};
      r_dat_sync <= {r_dat_sync[0], ps2_dat_i};
      r_state    <= w_state_nxt;
      r_clk_oe   <= w_clk_oe_nxt;
      r_dat_oe   <= w_dat_oe_nxt;
      if (w_cnt_clr)              r_cnt <= '0;
      else if (r_state != S_IDLE) r_cnt <= r_cnt + CW'(1);
      if (w_load) begin
        r_shift <= w_head;
        r_par   <= ~^w_head;
        r_bit   <= '0;
      end else if (w_bit_inc) begin
        r_bit   <= r_bit + 4'd1;
      end
      r_busy  <= w_load | (r_busy & ~(w_set_done | w_set_err));
      r_done  <= w_set_done | (r_done & ~w_w1c[0]);
      r_err   <= w_set_err  | (r_err  & ~w_w1c[1]);
      r_nack  <= w_set_nack | (r_nack & ~w_w1c[2]);
      if (w_wr_ctrl) r_irqen <= pwdata[0];
    end
  end

  always_comb begin
    prdata = 32'h0;
    if (w_rd) begin
      case (paddr[3:2])
        2'd1:    prdata = {26'h0, w_st_ext, r_nack, r_err, r_done, r_busy};
        2'd2:    prdata = {31'h0, r_irqen};
        default: prdata = 32'h0;
      endcase
    end
  end

  assign pready     = 1'b1;
  assign pslverr    = w_wr_tx & w_refuse;
  assign ps2_clk_oe = r_clk_oe;
  assign ps2_dat_oe = r_dat_oe;
  assign irq_o      = r_irqen & (r_done | r_err);

endmodule
